// File: rtl/tinyrv1_mem_pkg.sv
// Shared constants for the TinyRV1 memory responder: MMIO map, request types
// and STATUS word bit positions.
package tinyrv1_mem_pkg;

    localparam logic [31:0] MMIO_OUT    = 32'h0000_2000;
    localparam logic [31:0] MMIO_IN     = 32'h0000_2004;
    localparam logic [31:0] MMIO_STATUS = 32'h0000_2008;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    localparam int STATUS_FULL_BIT     = 0;
    localparam int STATUS_IN_VAL_BIT   = 1;
    localparam int STATUS_OVERFLOW_BIT = 2;

endpackage

// File: rtl/mem_word_fifo.sv
// Circular synchronous word FIFO with val/rdy on both sides. When full, an
// enqueue is still accepted if a dequeue happens in the same cycle.
module mem_word_fifo #(
    parameter int p_depth = 4,
    parameter int p_width = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_width-1:0] enq_data,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_width-1:0] deq_data,
    output logic               full
);
    localparam int PW = $clog2(p_depth);
    localparam int CW = PW + 1;

    logic [p_width-1:0] slot_reg [p_depth];
    logic [PW-1:0]      head_reg;
    logic [PW-1:0]      tail_reg;
    logic [CW-1:0]      count_reg;
    logic [CW-1:0]      count_next;
    logic               enq_fire;
    logic               deq_fire;

    assign full     = (count_reg == CW'(p_depth));
    assign deq_val  = (count_reg != '0);
    assign enq_rdy  = !full || deq_rdy;
    assign enq_fire = enq_val && enq_rdy;
    assign deq_fire = deq_val && deq_rdy;
    assign deq_data = slot_reg[head_reg];

    always_comb begin
        count_next = count_reg;
        if (enq_fire && !deq_fire)
            count_next = count_reg + CW'(1);
        else if (deq_fire && !enq_fire)
            count_next = count_reg - CW'(1);
    end

    // Storage is not reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (enq_fire)
            slot_reg[tail_reg] <= enq_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (enq_fire)
                tail_reg <= tail_reg + PW'(1);
            if (deq_fire)
                head_reg <= head_reg + PW'(1);
        end
    end

endmodule

// File: rtl/tinyrv1_mem.sv
// TinyRV1 zero-latency instruction/data memory with optional MMIO region
// (output FIFO, input port, STATUS), enabled by TINYRV1_MEM_MMIO_EN.
module tinyrv1_mem
    import tinyrv1_mem_pkg::*;
#(
    parameter int p_words      = 256,
    parameter int p_fifo_depth = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imemreq_val,
    input  logic [31:0] imemreq_addr,
    output logic [31:0] imemresp_data,
    input  logic        dmemreq_val,
    input  logic        dmemreq_type,
    input  logic [31:0] dmemreq_addr,
    input  logic [31:0] dmemreq_wdata,
    output logic [31:0] dmemresp_rdata,
    output logic        out_val,
    input  logic        out_rdy,
    output logic [31:0] out_data,
    input  logic        in_val,
    output logic        in_rdy,
    input  logic [31:0] in_data,
    output logic        overflow
);
    localparam int IW = $clog2(p_words);

    logic [31:0]   mem [p_words];
    logic [IW-1:0] i_idx;
    logic [IW-1:0] d_idx;
    logic          dmem_load;
    logic          dmem_store;
    logic          ram_we;
    logic          unused_addr_bits;

    assign i_idx            = imemreq_addr[2 +: IW];
    assign d_idx            = dmemreq_addr[2 +: IW];
    assign dmem_load        = dmemreq_val && (dmemreq_type == MEMREQ_READ);
    assign dmem_store       = dmemreq_val && (dmemreq_type == MEMREQ_WRITE);
    assign imemresp_data    = imemreq_val ? mem[i_idx] : 32'h0;
    assign unused_addr_bits = ^{imemreq_addr, dmemreq_addr};

    // RAM write is deliberately not gated by rst.
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[d_idx] <= dmemreq_wdata;
    end

`ifdef TINYRV1_MEM_MMIO_EN
    logic        is_out;
    logic        is_in;
    logic        is_status;
    logic        fifo_enq_val;
    logic        fifo_enq_rdy;
    logic        fifo_full;
    logic        overflow_reg;
    logic        overflow_next;
    logic [31:0] status_word;

    assign is_out       = (dmemreq_addr == MMIO_OUT);
    assign is_in        = (dmemreq_addr == MMIO_IN);
    assign is_status    = (dmemreq_addr == MMIO_STATUS);
    assign ram_we       = dmem_store && !(is_out || is_in || is_status);
    assign in_rdy       = dmem_load && is_in;
    assign fifo_enq_val = dmem_store && is_out;
    assign overflow     = overflow_reg;

    mem_word_fifo #(
        .p_depth (p_fifo_depth),
        .p_width (32)
    ) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .enq_val  (fifo_enq_val),
        .enq_rdy  (fifo_enq_rdy),
        .enq_data (dmemreq_wdata),
        .deq_val  (out_val),
        .deq_rdy  (out_rdy),
        .deq_data (out_data),
        .full     (fifo_full)
    );

    always_comb begin
        status_word                      = '0;
        status_word[STATUS_FULL_BIT]     = fifo_full;
        status_word[STATUS_IN_VAL_BIT]   = in_val;
        status_word[STATUS_OVERFLOW_BIT] = overflow_reg;
    end

    always_comb begin
        dmemresp_rdata = '0;
        if (dmem_load) begin
            if (is_out)
                dmemresp_rdata = '0;
            else if (is_in)
                dmemresp_rdata = in_val ? in_data : 32'h0;
            else if (is_status)
                dmemresp_rdata = status_word;
            else
                dmemresp_rdata = mem[d_idx];
        end
    end

    // A STATUS store and a dropped enqueue share the single data port, so
    // they never compete.
    always_comb begin
        overflow_next = overflow_reg;
        if (dmem_store && is_status)
            overflow_next = 1'b0;
        else if (fifo_enq_val && !fifo_enq_rdy)
            overflow_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            overflow_reg <= 1'b0;
        else
            overflow_reg <= overflow_next;
    end
`else
    logic unused_mmio_inputs;

    assign ram_we             = dmem_store;
    assign dmemresp_rdata     = dmem_load ? mem[d_idx] : 32'h0;
    assign out_val            = 1'b0;
    assign out_data           = 32'h0;
    assign in_rdy             = 1'b0;
    assign overflow           = 1'b0;
    assign unused_mmio_inputs = ^{out_rdy, in_val, in_data};
`endif

endmodule

// File: tb/tb_tinyrv1_mem.sv
// Self-checking bench for tinyrv1_mem: directed scenarios then random traffic
// against a queue/array reference model.
module tb_tinyrv1_mem;
`ifdef TINYRV1_MEM_MMIO_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imemreq_val = 1'b0;
    logic [31:0] imemreq_addr = '0;
    logic [31:0] imemresp_data;
    logic        dmemreq_val = 1'b0;
    logic        dmemreq_type = 1'b0;
    logic [31:0] dmemreq_addr = '0;
    logic [31:0] dmemreq_wdata = '0;
    logic [31:0] dmemresp_rdata;
    logic        out_val;
    logic        out_rdy = 1'b0;
    logic [31:0] out_data;
    logic        in_val = 1'b0;
    logic        in_rdy;
    logic [31:0] in_data = '0;
    logic        overflow;

    tinyrv1_mem #(.p_words(256), .p_fifo_depth(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imemreq_val    (imemreq_val),
        .imemreq_addr   (imemreq_addr),
        .imemresp_data  (imemresp_data),
        .dmemreq_val    (dmemreq_val),
        .dmemreq_type   (dmemreq_type),
        .dmemreq_addr   (dmemreq_addr),
        .dmemreq_wdata  (dmemreq_wdata),
        .dmemresp_rdata (dmemresp_rdata),
        .out_val        (out_val),
        .out_rdy        (out_rdy),
        .out_data       (out_data),
        .in_val         (in_val),
        .in_rdy         (in_rdy),
        .in_data        (in_data),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: word-addressed RAM with a written map, FIFO as a queue.
    logic [31:0] mem_m [256];
    bit          wr_m  [256];
    logic [31:0] fifo_m [$];
    bit          ovf_m = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'hFF);
    endfunction

    task automatic do_cycle(input bit r, input bit iv, input logic [31:0] ia,
                            input bit dv, input bit dt, input logic [31:0] da,
                            input logic [31:0] wd, input bit ordy,
                            input bit inv, input logic [31:0] ind);
        logic [31:0] exp;
        bit known, ld, st, is_o, is_i, is_s, full, deq;
        @(negedge clk);
        rst = r; imemreq_val = iv; imemreq_addr = ia;
        dmemreq_val = dv; dmemreq_type = dt; dmemreq_addr = da; dmemreq_wdata = wd;
        out_rdy = ordy; in_val = inv; in_data = ind;
        #1;
        $display("txn t=%0t rst=%0b if=%0b@%h d=%0b/%0b@%h wd=%h ordy=%0b in=%0b/%h q=%0d",
                 $time, r, iv, ia, dv, dt, da, wd, ordy, inv, ind, fifo_m.size());
        ld   = dv && !dt;
        st   = dv && dt;
        is_o = MM && (da == 32'h2000);
        is_i = MM && (da == 32'h2004);
        is_s = MM && (da == 32'h2008);

        if (!iv)
            check("imem_idle", imemresp_data, 32'h0);
        else if (wr_m[widx(ia)])
            check("imem_data", imemresp_data, mem_m[widx(ia)]);

        known = 1'b1;
        exp   = 32'h0;
        if (ld) begin
            if (is_o)      exp = 32'h0;
            else if (is_i) exp = inv ? ind : 32'h0;
            else if (is_s) exp = {29'b0, ovf_m, inv, fifo_m.size() == DEPTH};
            else begin
                known = wr_m[widx(da)];
                exp   = mem_m[widx(da)];
            end
        end
        if (known)
            check("dmem_rdata", dmemresp_rdata, exp);
        check("in_rdy", {31'b0, in_rdy}, {31'b0, ld && is_i});
        check("out_val", {31'b0, out_val}, {31'b0, fifo_m.size() != 0});
        if (fifo_m.size() != 0)
            check("out_data", out_data, fifo_m[0]);
        check("overflow", {31'b0, overflow}, {31'b0, ovf_m});

        // next-state prediction for the coming edge
        full = (fifo_m.size() == DEPTH);
        deq  = (fifo_m.size() != 0) && ordy;
        if (st && !(is_o || is_i || is_s)) begin
            mem_m[widx(da)] = wd;
            wr_m[widx(da)]  = 1'b1;
        end
        if (r) begin
            fifo_m.delete();
            ovf_m = 1'b0;
        end else begin
            if (deq)
                void'(fifo_m.pop_front());
            if (st && is_o) begin
                if (!full || deq) fifo_m.push_back(wd);
                else              ovf_m = 1'b1;
            end
            if (st && is_s)
                ovf_m = 1'b0;
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input bit ordy);
        do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, a, d, ordy, 1'b0, 32'h0);
    endtask

    task automatic load(input logic [31:0] a, input bit inv, input logic [31:0] ind);
        do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, a, 32'h0, 1'b0, inv, ind);
    endtask

    task automatic idle(input bit r, input bit ordy);
        do_cycle(r, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, ordy, 1'b0, 32'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        idle(1'b0, 1'b0);

        store(32'h10, 32'hDEAD_BEEF, 1'b0);
        do_cycle(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0);
        load(32'h13, 1'b0, 32'h0);
        // same-cycle fetch of a word being stored sees the old value
        do_cycle(1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h10, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0);
        store(32'h10, 32'hDEAD_BEEF, 1'b0);
        store(32'h404, 32'h1234, 1'b0);
        load(32'h4, 1'b0, 32'h0);

        for (int i = 1; i <= 5; i++)
            store(32'h2000, 32'(i), 1'b0);
        load(32'h2008, 1'b0, 32'h0);
        store(32'h2008, 32'h0, 1'b0);
        idle(1'b0, 1'b0);
        store(32'h2000, 32'h6, 1'b1);
        for (int i = 0; i < 5; i++)
            idle(1'b0, 1'b1);

        load(32'h2004, 1'b1, 32'hA5);
        load(32'h2004, 1'b0, 32'hA5);

        store(32'h2000, 32'h77, 1'b0);
        store(32'h2000, 32'h88, 1'b0);
        do_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0);
        idle(1'b0, 1'b0);
        load(32'h10, 1'b0, 32'h0);
        load(32'h20, 1'b0, 32'h0);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ia, da;
            int sel;
            ia  = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 63)) << 2);
            sel = $urandom_range(0, 7);
            if (sel == 0)      da = 32'h2000;
            else if (sel == 1) da = 32'h2004;
            else if (sel == 2) da = 32'h2008;
            else if (sel == 3) da = $urandom;
            else               da = (32'($urandom_range(0, 63)) << 2) | ($urandom & 32'h3);
            do_cycle($urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1, ia,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, da, $urandom,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tinyrv1_mem.md
# tinyrv1_mem

Memory-side responder for the TinyRV1 pipelined processor: serves the instruction-fetch port in F and the data load/store port in M with same-cycle read data and clock-edge writes, so the processor never stalls on memory. It also carries a small memory-mapped I/O region: an output word FIFO with a val/rdy drain port, an input word port, and a status word. It sits beside the processor datapath in the top-level and in test harnesses.

## Interface
- p_words, 256: memory depth in 32-bit words (power of two, ≥ 4).
- p_fifo_depth, 4: output FIFO depth in words (power of two, ≥ 2).
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- imemreq_val  input  1  fetch request valid.
- imemreq_addr  input  32  fetch byte address.
- imemresp_data  output  32  fetched instruction, combinational.
- dmemreq_val  input  1  data request valid.
- dmemreq_type  input  1  0 = load, 1 = store.
- dmemreq_addr  input  32  data byte address.
- dmemreq_wdata  input  32  store data.
- dmemresp_rdata  output  32  load data, combinational.
- out_val / out_rdy  output / input  1 / 1  output FIFO drain handshake.
- out_data  output  32  FIFO head word.
- in_val / in_rdy  input / output  1 / 1  input port handshake.
- in_data  input  32  input word.
- overflow  output  1  sticky flag: a store to OUT was dropped.

## Operation
- Word index = addr[2 +: $clog2(p_words)]. addr[1:0] is ignored. Upper bits are ignored, so addresses wrap modulo the memory size.
- imemresp_data = mem[index] when imemreq_val, else 0.
- Load: dmemresp_rdata = mem[index] (or the MMIO value). When not loading, the output is 0.
- Store: mem[index] <= wdata at the clock edge. A fetch of the same word in that cycle returns the old value.
- MMIO addresses (full 32-bit compare) take priority over the RAM:
  - 0x0000_2000 OUT: a store enqueues wdata. A load returns 0.
  - 0x0000_2004 IN: a load asserts in_rdy combinationally and returns in_data if in_val, else 0. A store is ignored.
  - 0x0000_2008 STATUS: a load returns {29'b0, overflow, in_val, fifo_full}. A store clears overflow.
- MMIO accesses never modify the RAM.
- Output FIFO is circular with head/tail pointers and a count of width $clog2(p_fifo_depth)+1.
  - out_val = (count != 0). out_data = head word.
  - Dequeue when out_val & out_rdy.
- Enqueue when full:
  - If a dequeue happens in the same cycle, the enqueue is accepted and count is unchanged.
  - Otherwise the word is dropped and overflow is set.
- Enqueue and dequeue together when not full: count is unchanged and both pointers advance.
- A STATUS store and an overflow-setting drop cannot coincide, because there is a single data port.

## Timing
- Reads are zero latency (combinational). Writes, FIFO and flag updates take effect at the next posedge.
- A word enqueued at edge N is visible on out_val/out_data after edge N. There is no bypass to out_data in the same cycle.
- in_rdy is a combinational function of the dmem request. The consumer side samples in_val & in_rdy at the edge.
- Reset values:
  - out_val 0; count, head and tail 0.
  - overflow 0; in_rdy 0 (follows the request).
  - imemresp_data and dmemresp_rdata 0 while their val is low.
  - RAM contents are not reset.
- Reset mid-operation: a store in the reset cycle is still written to the RAM. All FIFO state is cleared and queued words are lost.

## Configuration
- TINYRV1_MEM_MMIO_EN defined: the MMIO region, FIFO, in/out ports and overflow behave as above.
- Not defined:
  - All addresses map to the RAM.
  - out_val, in_rdy and overflow are tied to 0; out_data is tied to 0.
  - No FIFO is instantiated.

## Structure
- Shared package tinyrv1_mem_pkg holds:
  - MMIO address constants MMIO_OUT, MMIO_IN and MMIO_STATUS.
  - Request type constants MEMREQ_READ = 0 and MEMREQ_WRITE = 1.
  - STATUS bit positions.
- One sub-module, mem_word_fifo: a parameterised synchronous FIFO exposing enq_val, enq_rdy, deq_val, deq_rdy, deq_data and full. It is instantiated only under the macro.

## Test plan
- Store 0xDEAD_BEEF to 0x0000_0010, then load 0x10 and fetch 0x10 → both return 0xDEAD_BEEF. Load 0x13 → same word.
- With p_words=256, store 0x1234 to 0x0000_0404, then load 0x0000_0004 → 0x1234 (wrap-around).
- out_rdy=0: store 1..5 to 0x2000 → out_val=1, out_data=1, overflow=1 after the 5th store. Load 0x2008 → 0x5. Store 0x2008 → overflow=0.
- FIFO full with out_rdy=1 while storing 6 to 0x2000 → word 1 drains, 6 is accepted, overflow stays 0. Draining then yields 2,3,4,6.
- in_val=1, in_data=0xA5: load 0x2004 → rdata=0xA5 and in_rdy=1 in the same cycle. With in_val=0 → rdata=0.
- Fill the FIFO with 2 words, assert rst for one cycle → out_val=0 and overflow=0. Previously stored RAM words are still readable.
